id_stage: RTL

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register, the 32×32 general register file and the branch/jump resolution logic. It returns `Jump`, `BranchD`, `Jump_addr`, `Jump_reg` and `beq_addr` to fetch's next-PC mux in the same cycle, and it presents decoded operands to the execute stage.

---
 rtl/id_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file with write-first
// bypass, and same-cycle branch/jump resolution feeding fetch's next-PC mux.
module id_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [31:0]      InstrF,
    input  logic [WIDTH-1:0] PC_add_4F,
    input  logic             RegWriteW,
    input  logic [4:0]       WriteRegW,
    input  logic [WIDTH-1:0] ResultW,
    input  logic             ForwardAD,
    input  logic             ForwardBD,
    input  logic [WIDTH-1:0] ALUOutM,
    output logic             Jump,
    output logic             BranchD,
    output logic [WIDTH-1:0] Jump_addr,
    output logic [WIDTH-1:0] Jump_reg,
    output logic [WIDTH-1:0] beq_addr,
    output logic [31:0]      InstrD,
    output logic [WIDTH-1:0] PC_add_4D,
    output logic [WIDTH-1:0] RD1D,
    output logic [WIDTH-1:0] RD2D,
    output logic [4:0]       RsD,
    output logic [4:0]       RtD,
    output logic [4:0]       RdD,
    output logic [WIDTH-1:0] ImmD,
    output logic             LinkD,
    output logic [WIDTH-1:0] LinkAddrD,
    output logic             BDelaySlotD
);

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpRegimm  = 6'b000001;
    localparam logic [5:0] OpJ       = 6'b000010;
    localparam logic [5:0] OpJal     = 6'b000011;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpBne     = 6'b000101;
    localparam logic [5:0] OpBlez    = 6'b000110;
    localparam logic [5:0] OpBgtz    = 6'b000111;
    localparam logic [5:0] FnJr      = 6'b001000;
    localparam logic [5:0] FnJalr    = 6'b001001;
    localparam logic [4:0] RtBltz    = 5'b00000;
    localparam logic [4:0] RtBgez    = 5'b00001;
    localparam logic [4:0] RtBltzal  = 5'b10000;
    localparam logic [4:0] RtBgezal  = 5'b10001;

    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] pc_add_4_q, pc_add_4_d;
    logic             bdelay_q, bdelay_d;
    logic [WIDTH-1:0] rf_q [32];

    logic             is_branch_jump;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rf_rd1, rf_rd2;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];

    // IF/ID register: reset/flush > stall > load
    always_comb begin
        instr_d    = instr_q;
        pc_add_4_d = pc_add_4_q;
        bdelay_d   = bdelay_q;
        if (rst || FlushD) begin
            instr_d    = '0;
            pc_add_4_d = '0;
            bdelay_d   = 1'b0;
        end else if (!StallD) begin
            instr_d    = InstrF;
            pc_add_4_d = PC_add_4F;
            bdelay_d   = is_branch_jump;
        end
    end

    always_ff @(posedge clk) begin
        instr_q    <= instr_d;
        pc_add_4_q <= pc_add_4_d;
        bdelay_q   <= bdelay_d;
    end

    // Register contents survive reset; r0 is never written.
    always_ff @(posedge clk) begin
        if (RegWriteW && (WriteRegW != 5'd0)) begin
            rf_q[WriteRegW] <= ResultW;
        end
    end

    always_comb begin
        rf_rd1 = '0;
        rf_rd2 = '0;
        if (RsD != 5'd0) begin
            rf_rd1 = (RegWriteW && (WriteRegW == RsD)) ? ResultW : rf_q[RsD];
        end
        if (RtD != 5'd0) begin
            rf_rd2 = (RegWriteW && (WriteRegW == RtD)) ? ResultW : rf_q[RtD];
        end
    end

    assign InstrD      = instr_q;
    assign PC_add_4D   = pc_add_4_q;
    assign BDelaySlotD = bdelay_q;
    assign RsD         = instr_q[25:21];
    assign RtD         = instr_q[20:16];
    assign RdD         = instr_q[15:11];
    assign ImmD        = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};
    assign RD1D        = ForwardAD ? ALUOutM : rf_rd1;
    assign RD2D        = ForwardBD ? ALUOutM : rf_rd2;
    assign Jump_addr   = {pc_add_4_q[WIDTH-1:WIDTH-4], instr_q[25:0], 2'b00};
    assign beq_addr    = pc_add_4_q + (ImmD << 2);
    assign Jump_reg    = RD1D;
    assign LinkAddrD   = pc_add_4_q + WIDTH'(4);

    // Next-PC select: {Jump, BranchD} = 11 J/JAL, 10 JR/JALR, 01 taken branch
    always_comb begin
        Jump           = 1'b0;
        BranchD        = 1'b0;
        LinkD          = 1'b0;
        is_branch_jump = 1'b0;
        case (opcode)
            OpJ: begin
                Jump           = 1'b1;
                BranchD        = 1'b1;
                is_branch_jump = 1'b1;
            end
            OpJal: begin
                Jump           = 1'b1;
                BranchD        = 1'b1;
                LinkD          = 1'b1;
                is_branch_jump = 1'b1;
            end
            OpSpecial: begin
                if (funct == FnJr || funct == FnJalr) begin
                    Jump           = 1'b1;
                    is_branch_jump = 1'b1;
                    LinkD          = (funct == FnJalr);
                end
            end
            OpBeq: begin
                is_branch_jump = 1'b1;
                BranchD        = (RD1D == RD2D);
            end
            OpBne: begin
                is_branch_jump = 1'b1;
                BranchD        = (RD1D != RD2D);
            end
            OpBlez: begin
                is_branch_jump = 1'b1;
                BranchD        = RD1D[WIDTH-1] || (RD1D == '0);
            end
            OpBgtz: begin
                is_branch_jump = 1'b1;
                BranchD        = !RD1D[WIDTH-1] && (RD1D != '0);
            end
            OpRegimm: begin
                case (RtD)
                    RtBltz, RtBltzal: begin
                        is_branch_jump = 1'b1;
                        BranchD        = RD1D[WIDTH-1];
                        LinkD          = (RtD == RtBltzal);
                    end
                    RtBgez, RtBgezal: begin
                        is_branch_jump = 1'b1;
                        BranchD        = !RD1D[WIDTH-1];
                        LinkD          = (RtD == RtBgezal);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
